ad9467_spi_cfg: RTL

//  Configuration sequencer for the AD9467 ADC SPI port (3-wire: CSB/SCLK/SDIO).

---
 rtl/ad9467_spi_cfg.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ad9467_spi_cfg.sv
// ad9467_spi_cfg: configuration sequencer for the AD9467 3-wire SPI port.
//
// On start it writes a fixed four-entry init table (ending with the transfer
// write 0xFF<-0x01) and then raises the sticky cfg_done flag. While idle it
// serves single host register reads/writes through a req/ack handshake.
//
// Ports:
//   sclk, rst               system clock, asynchronous active-high reset
//   start                   pulse: run the init table (ignored while busy)
//   host_req/wr/addr/wdata  host access request, held until host_ack
//   host_ack, host_rdata    completion pulse and read data (held until next read)
//   busy, cfg_done          sequencer activity and init-complete flag
//   spi_csb/clk/sdo/sdo_oe  SPI drive; the tristate for SDIO is built above
//   spi_sdi                 sampled SDIO value

module ad9467_spi_cfg #(
    parameter int unsigned CLK_DIV = 4,  // sclk cycles per SPI half-bit, 2..255
    parameter int unsigned GAP_CYC = 8   // min sclk cycles CSB high between frames, >= 1
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        start,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [12:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        busy,
    output logic        cfg_done,
    output logic        spi_csb,
    output logic        spi_clk,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic        spi_sdi
);

    // Sequencer states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INIT      = 3'd1;
    localparam logic [2:0] ST_INIT_WAIT = 3'd2;
    localparam logic [2:0] ST_HOST      = 3'd3;
    localparam logic [2:0] ST_HOST_WAIT = 3'd4;
    localparam logic [2:0] ST_ACK       = 3'd5;

    // Frame engine phases
    localparam logic [2:0] FP_IDLE  = 3'd0;
    localparam logic [2:0] FP_SETUP = 3'd1;
    localparam logic [2:0] FP_LOW   = 3'd2;
    localparam logic [2:0] FP_HIGH  = 3'd3;
    localparam logic [2:0] FP_HOLD  = 3'd4;
    localparam logic [2:0] FP_GAP   = 3'd5;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    function automatic logic [23:0] init_word(input logic [1:0] idx);
        logic [23:0] w;
        case (idx)
            2'd0:    w = {1'b0, 2'b00, 13'h0000, 8'h18};  // SDO config, MSB first
            2'd1:    w = {1'b0, 2'b00, 13'h0014, 8'h01};  // two's complement output
            2'd2:    w = {1'b0, 2'b00, 13'h0016, 8'h00};  // clock phase default
            default: w = {1'b0, 2'b00, 13'h00FF, 8'h01};  // transfer
        endcase
        return w;
    endfunction

    // Sequencer state
    logic [2:0]  st_q, st_d;
    logic [1:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        host_ack_q, host_ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        cfg_done_q, cfg_done_d;

    // Frame engine state
    logic [2:0]  fph_q, fph_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] shift_q, shift_d;
    logic        rd_frame_q, rd_frame_d;
    logic [7:0]  rsh_q, rsh_d;
    logic        csb_q, csb_d;
    logic        clk_q, clk_d;
    logic        sdo_q, sdo_d;
    logic        oe_q, oe_d;

    logic        frame_go;
    logic [23:0] frame_word;
    logic        frame_done;

    // Sequencer
    always_comb begin
        st_d       = st_q;
        idx_d      = idx_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        host_ack_d = 1'b0;
        rdata_d    = rdata_q;
        cfg_done_d = cfg_done_q;
        frame_go   = 1'b0;
        frame_word = init_word(idx_q);

        case (st_q)
            ST_IDLE: begin
                // start has priority; a concurrent host_req stays pending
                if (start) begin
                    st_d       = ST_INIT;
                    idx_d      = 2'd0;
                    cfg_done_d = 1'b0;
                end else if (host_req) begin
                    st_d    = ST_HOST;
                    wr_d    = host_wr;
                    addr_d  = host_addr;
                    wdata_d = host_wdata;
                end
            end
            ST_INIT: begin
                frame_go = 1'b1;
                st_d     = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (frame_done) begin
                    if (idx_q == 2'd3) begin
                        cfg_done_d = 1'b1;
                        st_d       = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        st_d  = ST_INIT;
                    end
                end
            end
            ST_HOST: begin
                frame_go   = 1'b1;
                frame_word = {~wr_q, 2'b00, addr_q, (wr_q ? wdata_q : 8'h00)};
                st_d       = ST_HOST_WAIT;
            end
            ST_HOST_WAIT: begin
                if (frame_done) begin
                    host_ack_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d = rsh_q;
                    end
                    st_d = ST_ACK;
                end
            end
            // One cycle for the ack so the host can drop req before IDLE looks again
            ST_ACK:  st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase

        busy_d = (st_d != ST_IDLE);
    end

    // Frame engine: SETUP, 24 x (LOW, HIGH), HOLD, then GAP with CSB high
    always_comb begin
        fph_d      = fph_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rd_frame_d = rd_frame_q;
        rsh_d      = rsh_q;
        csb_d      = csb_q;
        clk_d      = clk_q;
        sdo_d      = sdo_q;
        oe_d       = oe_q;
        frame_done = 1'b0;

        case (fph_q)
            FP_IDLE: begin
                if (frame_go) begin
                    fph_d      = FP_SETUP;
                    cnt_d      = 16'd0;
                    bit_d      = 5'd0;
                    shift_d    = frame_word;
                    rd_frame_d = frame_word[23];
                    csb_d      = 1'b0;
                    oe_d       = 1'b1;
                end
            end
            FP_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    fph_d = FP_LOW;
                    cnt_d = 16'd0;
                    sdo_d = shift_q[23];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FP_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    fph_d = FP_HIGH;
                    cnt_d = 16'd0;
                    clk_d = 1'b1;
                    // Data phase of a read: capture on the rising edge
                    if (rd_frame_q && (bit_q >= 5'd16)) begin
                        rsh_d = {rsh_q[6:0], spi_sdi};
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FP_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 16'd0;
                    clk_d = 1'b0;
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd23) begin
                        fph_d = FP_HOLD;
                    end else begin
                        fph_d   = FP_LOW;
                        shift_d = {shift_q[22:0], 1'b0};
                        sdo_d   = shift_q[22];
                        // Release SDIO on the falling edge that starts bit 17
                        if (rd_frame_q && (bit_q == 5'd15)) begin
                            oe_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FP_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    fph_d = FP_GAP;
                    cnt_d = 16'd0;
                    csb_d = 1'b1;
                    oe_d  = 1'b0;
                    sdo_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FP_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    fph_d      = FP_IDLE;
                    cnt_d      = 16'd0;
                    frame_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                fph_d = FP_IDLE;
                csb_d = 1'b1;
                clk_d = 1'b0;
                oe_d  = 1'b0;
            end
        endcase
    end

    // Asynchronous reset drops the frame immediately: CSB high, clk low, oe off
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            idx_q      <= 2'd0;
            wr_q       <= 1'b0;
            addr_q     <= 13'd0;
            wdata_q    <= 8'd0;
            host_ack_q <= 1'b0;
            rdata_q    <= 8'd0;
            busy_q     <= 1'b0;
            cfg_done_q <= 1'b0;
            fph_q      <= FP_IDLE;
            cnt_q      <= 16'd0;
            bit_q      <= 5'd0;
            shift_q    <= 24'd0;
            rd_frame_q <= 1'b0;
            rsh_q      <= 8'd0;
            csb_q      <= 1'b1;
            clk_q      <= 1'b0;
            sdo_q      <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            st_q       <= st_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            host_ack_q <= host_ack_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            cfg_done_q <= cfg_done_d;
            fph_q      <= fph_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rd_frame_q <= rd_frame_d;
            rsh_q      <= rsh_d;
            csb_q      <= csb_d;
            clk_q      <= clk_d;
            sdo_q      <= sdo_d;
            oe_q       <= oe_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_rdata = rdata_q;
    assign busy       = busy_q;
    assign cfg_done   = cfg_done_q;
    assign spi_csb    = csb_q;
    assign spi_clk    = clk_q;
    assign spi_sdo    = sdo_q;
    assign spi_sdo_oe = oe_q;

endmodule
